// File: rtl/apple_placer.sv
// apple_placer: picks a free apple cell on the 7x6 snake grid.
// A request loads a pseudo-random start cell taken from a free-running LFSR. The occupancy
// bitmap is then scanned one cell per clock, wrapping around the board, until a free cell
// is found or every cell has been checked.
//
// Ports:
//   i_Clk          game clock, all state on the rising edge
//   i_Reset        asynchronous active-high reset
//   i_Occupied     occupancy bitmap, bit n = cell n (n = Y*7+X); held stable while o_Busy
//   i_Req          placement request, only sampled while idle
//   o_Busy         search in progress
//   o_Done         one-cycle pulse when the search has finished
//   o_Full         valid with o_Done; no free cell was found
//   o_Apple_X/Y    placed apple column / row
//   o_Apple_Index  placed apple linear index, Y*7+X
module apple_placer #(
   parameter int unsigned GRID_COLS = 7,
   parameter int unsigned GRID_ROWS = 6,
   parameter int unsigned CELLS     = 42,
   parameter logic [5:0]  LFSR_SEED = 6'h01
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic [CELLS-1:0] i_Occupied,
   input  logic             i_Req,
   output logic             o_Busy,
   output logic             o_Done,
   output logic             o_Full,
   output logic [2:0]       o_Apple_X,
   output logic [2:0]       o_Apple_Y,
   output logic [5:0]       o_Apple_Index
);

   localparam logic [2:0] LastX   = 3'(GRID_COLS - 1);
   localparam logic [2:0] LastY   = 3'(GRID_ROWS - 1);
   localparam logic [5:0] LastIdx = 6'(CELLS - 1);

   typedef enum logic [0:0] {StIdle, StScan} state_e;

   state_e     r_state, w_state_d;
   logic [5:0] r_lfsr;
   logic [2:0] r_cur_x, w_cur_x_d;
   logic [2:0] r_cur_y, w_cur_y_d;
   logic [5:0] r_cur_idx, w_cur_idx_d;
   logic [5:0] r_count, w_count_d;
   logic       r_busy, w_busy_d;
   logic       r_done, w_done_d;
   logic       r_full, w_full_d;
   logic [2:0] r_apple_x, w_apple_x_d;
   logic [2:0] r_apple_y, w_apple_y_d;
   logic [5:0] r_apple_idx, w_apple_idx_d;

   logic [2:0] w_x0, w_y0;
   logic [5:0] w_idx0;
   logic       w_cell_occ;

   // Fold the 3-bit LFSR fields into the legal X/Y ranges without a divider.
   always_comb begin
      w_x0 = (r_lfsr[2:0] == 3'd7) ? 3'd0 : r_lfsr[2:0];
      unique case (r_lfsr[5:3])
         3'd6:    w_y0 = 3'd0;
         3'd7:    w_y0 = 3'd1;
         default: w_y0 = r_lfsr[5:3];
      endcase
      // y0*7 as y0*8 - y0
      w_idx0 = {w_y0, 3'b000} - {3'b000, w_y0} + {3'b000, w_x0};
   end

   assign w_cell_occ = i_Occupied[r_cur_idx];

   always_comb begin
      w_state_d     = r_state;
      w_cur_x_d     = r_cur_x;
      w_cur_y_d     = r_cur_y;
      w_cur_idx_d   = r_cur_idx;
      w_count_d     = r_count;
      w_busy_d      = r_busy;
      w_done_d      = 1'b0;
      w_full_d      = r_full;
      w_apple_x_d   = r_apple_x;
      w_apple_y_d   = r_apple_y;
      w_apple_idx_d = r_apple_idx;
      unique case (r_state)
         StIdle: begin
            if (i_Req) begin
               w_cur_x_d   = w_x0;
               w_cur_y_d   = w_y0;
               w_cur_idx_d = w_idx0;
               w_count_d   = 6'd0;
               w_busy_d    = 1'b1;
               w_full_d    = 1'b0;
               w_state_d   = StScan;
            end
         end
         StScan: begin
            if (!w_cell_occ) begin
               w_apple_x_d   = r_cur_x;
               w_apple_y_d   = r_cur_y;
               w_apple_idx_d = r_cur_idx;
               w_done_d      = 1'b1;
               w_full_d      = 1'b0;
               w_busy_d      = 1'b0;
               w_state_d     = StIdle;
            end else if (r_count == LastIdx) begin
               // Every cell checked; apple outputs keep their last placement.
               w_done_d  = 1'b1;
               w_full_d  = 1'b1;
               w_busy_d  = 1'b0;
               w_state_d = StIdle;
            end else begin
               if (r_cur_x == LastX) begin
                  w_cur_x_d = 3'd0;
                  w_cur_y_d = (r_cur_y == LastY) ? 3'd0 : r_cur_y + 3'd1;
               end else begin
                  w_cur_x_d = r_cur_x + 3'd1;
               end
               w_cur_idx_d = (r_cur_idx == LastIdx) ? 6'd0 : r_cur_idx + 6'd1;
               w_count_d   = r_count + 6'd1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_state     <= StIdle;
         r_lfsr      <= LFSR_SEED;
         r_cur_x     <= 3'd0;
         r_cur_y     <= 3'd0;
         r_cur_idx   <= 6'd0;
         r_count     <= 6'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_full      <= 1'b0;
         r_apple_x   <= 3'd0;
         r_apple_y   <= 3'd0;
         r_apple_idx <= 6'd0;
      end else begin
         r_state     <= w_state_d;
         // x^6+x^5+1, free-running in every state
         r_lfsr      <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
         r_cur_x     <= w_cur_x_d;
         r_cur_y     <= w_cur_y_d;
         r_cur_idx   <= w_cur_idx_d;
         r_count     <= w_count_d;
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_full      <= w_full_d;
         r_apple_x   <= w_apple_x_d;
         r_apple_y   <= w_apple_y_d;
         r_apple_idx <= w_apple_idx_d;
      end
   end

   assign o_Busy        = r_busy;
   assign o_Done        = r_done;
   assign o_Full        = r_full;
   assign o_Apple_X     = r_apple_x;
   assign o_Apple_Y     = r_apple_y;
   assign o_Apple_Index = r_apple_idx;

endmodule
